// File: rtl/mc_control_fsm.sv
// Multicycle processor main controller.
// Moore FSM that sequences fetch, decode, memory, execute and branch steps,
// with a combinational ALU decoder and PC-write (PCS) logic.
//
// Ports
//   CLK, RESET                rising-edge clock, async active-high reset
//   Op, Funct, Rd             instruction fields, stable from DECODE onward
//   PCS, RegW, MemW, FlagW,   to the condition-logic stage
//   NoWrite
//   IRWrite, NextPC, AdrSrc,  datapath controls
//   ResultSrc, ALUSrcA,
//   ALUSrcB, ALUControl,
//   ImmSrc, RegSrc
//
// state  | meaning
// FETCH  | read instruction, PC <= PC+4
// DECODE | read registers, compute PC+8
// MEMADR | compute memory address
// MEMRD  | read data memory
// MEMWB  | write load data to register file
// MEMWR  | write data memory
// EXECR  | ALU op with register operand
// EXECI  | ALU op with immediate operand
// ALUWB  | write ALU result to register file
// BRANCH | compute branch target, write PC
module mc_control_fsm (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic       PCS,
  output logic       RegW,
  output logic       MemW,
  output logic [1:0] FlagW,
  output logic       NoWrite,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_t;

  state_t state, state_next;

  logic       branch;
  logic       alu_op;
  logic [1:0] dec_ctrl;
  logic       dec_nowrite;
  logic       dec_supported;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = FETCH;
    case (state)
      FETCH:  state_next = DECODE;
      DECODE: begin
        case (Op)
          2'b00:   state_next = Funct[5] ? EXECI : EXECR;
          2'b01:   state_next = MEMADR;
          2'b10:   state_next = BRANCH;
          default: state_next = FETCH;
        endcase
      end
      MEMADR: state_next = Funct[0] ? MEMRD : MEMWR;
      MEMRD:  state_next = MEMWB;
      EXECR:  state_next = ALUWB;
      EXECI:  state_next = ALUWB;
      default: state_next = FETCH;
    endcase
  end

  always_comb begin
    IRWrite   = 1'b0;
    NextPC    = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    RegW      = 1'b0;
    MemW      = 1'b0;
    alu_op    = 1'b0;
    branch    = 1'b0;
    case (state)
      FETCH: begin
        IRWrite   = 1'b1;
        NextPC    = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR: ALUSrcB = 2'b01;
      MEMRD:  AdrSrc  = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        RegW      = 1'b1;
      end
      MEMWR: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      EXECR: alu_op = 1'b1;
      EXECI: begin
        ALUSrcB = 2'b01;
        alu_op  = 1'b1;
      end
      ALUWB: RegW = 1'b1;
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    dec_ctrl      = 2'b00;
    dec_nowrite   = 1'b0;
    dec_supported = 1'b1;
    case (Funct[4:1])
      4'b0100: dec_ctrl = 2'b00;
      4'b0010: dec_ctrl = 2'b01;
      4'b0000: dec_ctrl = 2'b10;
      4'b1100: dec_ctrl = 2'b11;
      4'b1010: begin
        dec_ctrl    = 2'b01;
        dec_nowrite = 1'b1;
      end
      default: dec_supported = 1'b0;
    endcase
  end

  assign ALUControl = alu_op ? dec_ctrl : 2'b00;
  // Only add/sub-type operations (ctrl 00/01) update C and V.
  assign FlagW = (alu_op && dec_supported) ? {Funct[0], Funct[0] & ~dec_ctrl[1]} : 2'b00;
  // Funct is stable through ALUWB, so the decoded NoWrite can be re-derived
  // there without a register to suppress the write of a compare.
  assign NoWrite = (alu_op || state == ALUWB) && dec_nowrite;

  assign PCS    = branch | (RegW & (Rd == 4'b1111));
  assign ImmSrc = Op;
  assign RegSrc = {Op == 2'b01, Op == 2'b10};

endmodule

// File: tb/tb_mc_control_fsm.sv
module tb_mc_control_fsm;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       PCS, RegW, MemW, NoWrite, IRWrite, NextPC, AdrSrc, ALUSrcA;
  logic [1:0] FlagW, ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;

  mc_control_fsm dut (
    .CLK(CLK), .RESET(RESET), .Op(Op), .Funct(Funct), .Rd(Rd),
    .PCS(PCS), .RegW(RegW), .MemW(MemW), .FlagW(FlagW), .NoWrite(NoWrite),
    .IRWrite(IRWrite), .NextPC(NextPC), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc)
  );

  always #5 CLK = ~CLK;

  typedef enum int {S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
                    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH} step_e;

  int checks = 0;
  int failures = 0;
  step_e seq_q[$];

  logic [1:0] cap_ctrl, cap_flagw;
  logic       cap_nowrite, cap_pcs, cap_regw, cap_memw;

  function automatic logic [19:0] dut_vec();
    return {PCS, RegW, MemW, FlagW, NoWrite, IRWrite, NextPC, AdrSrc, ResultSrc,
            ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc};
  endfunction

  // Reference: the step list of an instruction class, by instruction kind.
  function automatic void build_seq(input logic [1:0] op, input logic [5:0] f);
    seq_q.delete();
    seq_q.push_back(S_FETCH);
    seq_q.push_back(S_DECODE);
    if (op == 2'b00) begin
      seq_q.push_back(f[5] ? S_EXECI : S_EXECR);
      seq_q.push_back(S_ALUWB);
    end else if (op == 2'b01) begin
      seq_q.push_back(S_MEMADR);
      if (f[0]) begin
        seq_q.push_back(S_MEMRD);
        seq_q.push_back(S_MEMWB);
      end else begin
        seq_q.push_back(S_MEMWR);
      end
    end else if (op == 2'b10) begin
      seq_q.push_back(S_BRANCH);
    end
  endfunction

  function automatic logic [19:0] model_out(input step_e s, input logic [1:0] op,
                                            input logic [5:0] f, input logic [3:0] rd);
    logic pcs = 0, regw = 0, memw = 0, nowr = 0, irw = 0, npc = 0, adr = 0, srca = 0, br = 0;
    logic [1:0] flagw = 0, res = 0, srcb = 0, ctrl = 0;
    int cmd;
    bit supported, arith, is_cmp;
    cmd = int'(f[4:1]);
    is_cmp = (cmd == 10);
    supported = (cmd == 4) || (cmd == 2) || (cmd == 0) || (cmd == 12) || is_cmp;
    arith = (cmd == 4) || (cmd == 2) || is_cmp;
    case (s)
      S_FETCH:  begin irw = 1; npc = 1; srca = 1; srcb = 2; res = 2; end
      S_DECODE: begin srca = 1; srcb = 2; res = 2; end
      S_MEMADR: srcb = 1;
      S_MEMRD:  adr = 1;
      S_MEMWB:  begin res = 1; regw = 1; end
      S_MEMWR:  begin adr = 1; memw = 1; end
      S_EXECR, S_EXECI: begin
        srcb = (s == S_EXECI) ? 2'd1 : 2'd0;
        if (cmd == 2 || is_cmp) ctrl = 1;
        else if (cmd == 0) ctrl = 2;
        else if (cmd == 12) ctrl = 3;
        if (supported) flagw = {f[0], f[0] & arith};
        nowr = is_cmp;
      end
      S_ALUWB:  begin regw = 1; nowr = is_cmp; end
      S_BRANCH: begin srcb = 1; res = 2; br = 1; end
      default: ;
    endcase
    pcs = br || (regw && rd == 4'd15);
    return {pcs, regw, memw, flagw, nowr, irw, npc, adr, res, srca, srcb, ctrl,
            op, (op == 2'b01), (op == 2'b10)};
  endfunction

  task automatic check(input string name, input logic [19:0] got, input logic [19:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%05h expected=%05h", name, got, exp);
    end
  endtask

  // Called just after a rising edge with the DUT in FETCH; leaves it there.
  task automatic run_instr(input string name, input logic [1:0] op,
                           input logic [5:0] f, input logic [3:0] rd);
    Op = op; Funct = f; Rd = rd;
    build_seq(op, f);
    for (int i = 0; i < seq_q.size(); i++) begin
      @(negedge CLK);
      check($sformatf("%s step%0d", name, i), dut_vec(), model_out(seq_q[i], op, f, rd));
      if (i == 2) begin
        cap_ctrl = ALUControl; cap_flagw = FlagW; cap_nowrite = NoWrite;
      end
      cap_pcs = PCS; cap_regw = RegW; cap_memw = MemW;
      @(posedge CLK); #1;
    end
  endtask

  task automatic measure_latency(input string name, input logic [1:0] op,
                                 input logic [5:0] f, input int exp_lat);
    int n = 0;
    Op = op; Funct = f; Rd = 4'd0;
    do begin
      @(posedge CLK); #1;
      n++;
    end while (!IRWrite && n < 12);
    checks++;
    if (n != exp_lat) begin
      failures++;
      $display("FAIL %s latency got=%0d expected=%0d", name, n, exp_lat);
    end
  endtask

  typedef struct {
    string      name;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    int         latency;
    logic [1:0] ctrl;
    logic [1:0] flagw;
    logic       nowrite;
    logic       last_pcs;
    logic       last_regw;
    logic       last_memw;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs.push_back('{"ADD",     2'b00, 6'b001000, 4'd1,  4, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{"SUBS_PC", 2'b00, 6'b100101, 4'd15, 4, 2'b01, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{"CMPS_I",  2'b00, 6'b110101, 4'd0,  4, 2'b01, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{"CMP_NS",  2'b00, 6'b010100, 4'd0,  4, 2'b01, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{"ANDS",    2'b00, 6'b000001, 4'd3,  4, 2'b10, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{"ORR_I",   2'b00, 6'b111000, 4'd4,  4, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{"UNSUP",   2'b00, 6'b001111, 4'd5,  4, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{"LDR",     2'b01, 6'b011001, 4'd2,  5, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{"LDR_PC",  2'b01, 6'b011001, 4'd15, 5, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{"STR",     2'b01, 6'b011000, 4'd2,  4, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{"B",       2'b10, 6'b000000, 4'd0,  3, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{"UNDEF",   2'b11, 6'b000000, 4'd0,  2, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0});

    RESET = 1'b1; Op = 2'b00; Funct = 6'd0; Rd = 4'd0;
    #2;
    check("reset_async", dut_vec(), model_out(S_FETCH, 2'b00, 6'd0, 4'd0));
    @(posedge CLK); #1;
    check("reset_held", dut_vec(), model_out(S_FETCH, 2'b00, 6'd0, 4'd0));
    RESET = 1'b0;

    foreach (vecs[k]) begin
      run_instr(vecs[k].name, vecs[k].op, vecs[k].funct, vecs[k].rd);
      checks++;
      if (vecs[k].op == 2'b00 &&
          {cap_ctrl, cap_flagw, cap_nowrite} !== {vecs[k].ctrl, vecs[k].flagw, vecs[k].nowrite}) begin
        failures++;
        $display("FAIL %s exec got=%b_%b_%b expected=%b_%b_%b", vecs[k].name,
                 cap_ctrl, cap_flagw, cap_nowrite, vecs[k].ctrl, vecs[k].flagw, vecs[k].nowrite);
      end
      checks++;
      if ({cap_pcs, cap_regw, cap_memw} !== {vecs[k].last_pcs, vecs[k].last_regw, vecs[k].last_memw}) begin
        failures++;
        $display("FAIL %s last pcs/regw/memw got=%b%b%b expected=%b%b%b", vecs[k].name,
                 cap_pcs, cap_regw, cap_memw, vecs[k].last_pcs, vecs[k].last_regw, vecs[k].last_memw);
      end
      measure_latency(vecs[k].name, vecs[k].op, vecs[k].funct, vecs[k].latency);
    end

    for (int r = 0; r < 80; r++) begin
      logic [1:0] op;
      logic [5:0] f;
      logic [3:0] rd;
      op = 2'($urandom_range(0, 3));
      f  = 6'($urandom);
      rd = ($urandom_range(0, 1) == 1) ? 4'd15 : 4'($urandom);
      run_instr($sformatf("rand%0d", r), op, f, rd);
    end

    // Reset in the middle of a store: MemW must drop without a clock edge.
    Op = 2'b01; Funct = 6'b011000; Rd = 4'd0;
    repeat (3) begin @(posedge CLK); #1; end
    checks++;
    if (MemW !== 1'b1) begin
      failures++;
      $display("FAIL memwr_before_reset MemW got=%b expected=1", MemW);
    end
    #2 RESET = 1'b1;
    #1;
    check("reset_in_memwr", dut_vec(), model_out(S_FETCH, 2'b01, 6'b011000, 4'd0));
    @(posedge CLK); #1;
    RESET = 1'b0;
    run_instr("after_reset_add", 2'b00, 6'b001000, 4'd1);
    run_instr("after_reset_und", 2'b11, 6'b101010, 4'd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mc_control_fsm.md
MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 SHALL provide ports: CLK  in  1  rising-edge clock; RESET  in  1  asynchronous active-high reset.
REQ-002 SHALL provide inputs from the instruction register: Op  in  2  Instr[27:26]; Funct  in  6  Instr[25:20]; Rd  in  4  Instr[15:12].
REQ-003 SHALL provide these outputs to the condition-logic stage: PCS  out  1; RegW  out  1; MemW  out  1; FlagW  out  2; NoWrite  out  1.
REQ-004 SHALL provide these datapath outputs: IRWrite  out  1; NextPC  out  1; AdrSrc  out  1; ResultSrc  out  2; ALUSrcA  out  1; ALUSrcB  out  2; ALUControl  out  2; ImmSrc  out  2; RegSrc  out  2.
REQ-005 Op encodings SHALL be 00 data-processing, 01 memory, 10 branch, 11 undefined; Funct[5]=I (immediate) bit, Funct[0]=S bit (DP) or L bit (memory).

Function
REQ-006 SHALL implement a Moore FSM with 10 states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH; one transition per CLK rising edge.
REQ-007 Transitions SHALL be: FETCH->DECODE; DECODE->MEMADR if Op=01, EXECR if Op=00 and Funct[5]=0, EXECI if Op=00 and Funct[5]=1, BRANCH if Op=10, FETCH if Op=11.
REQ-008 Transitions SHALL continue: MEMADR->MEMRD if Funct[0]=1, else MEMWR; MEMRD->MEMWB; EXECR/EXECI->ALUWB; MEMWB, MEMWR, ALUWB, BRANCH->FETCH.
REQ-009 Every signal not listed for a state SHALL be 0.
- FETCH: IRWrite=1, NextPC=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
REQ-010 Memory and execute states SHALL drive:
- MEMADR: ALUSrcB=01.
- MEMRD: AdrSrc=1.
- MEMWB: ResultSrc=01, RegW=1.
- MEMWR: AdrSrc=1, MemW=1.
- EXECR: ALUSrcB=00, ALUOp=1.
- EXECI: ALUSrcB=01, ALUOp=1.
- ALUWB: RegW=1.
- BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1.
ALUOp and Branch are internal signals.
REQ-011 PCS SHALL equal Branch OR (RegW AND Rd=4'b1111), combinationally.
REQ-012 When ALUOp=0: ALUControl=00 (add), FlagW=00, NoWrite=0.
REQ-013 When ALUOp=1, ALUControl SHALL be decoded from Funct[4:1]:
- 0100 ADD -> 00
- 0010 SUB -> 01
- 0000 AND -> 10
- 1100 ORR -> 11
- 1010 CMP -> 01 with NoWrite=1
- any other -> 00, FlagW=00, NoWrite=0
REQ-014 For supported commands when ALUOp=1: FlagW[1]=Funct[0]; FlagW[0]=Funct[0] AND (ALUControl is 00 or 01). CMP SHALL set FlagW=11 only when Funct[0]=1.
REQ-015 NoWrite SHALL be driven only in EXECR/EXECI. During the following ALUWB it SHALL hold the value decoded from the stable Funct, so the downstream stage suppresses the register write.
REQ-016 ImmSrc SHALL equal Op. RegSrc[0] SHALL be 1 iff Op=10. RegSrc[1] SHALL be 1 iff Op=01. Both are combinational in all states.
REQ-017 Op, Funct and Rd SHALL be treated as stable from DECODE through the last state of an instruction. The block SHALL NOT register them.
REQ-018 Instruction latency SHALL be:
- branch: 3 cycles
- DP: 4 cycles
- store: 4 cycles
- load: 5 cycles
- undefined: 2 cycles
REQ-019 Unreachable state encodings SHALL return to FETCH on the next edge, with all outputs 0.

Reset
REQ-020 RESET=1 SHALL force FETCH immediately, independent of CLK, including mid-instruction; any pending RegW/MemW SHALL drop in the same cycle.
REQ-021 During and directly after reset, outputs SHALL be FETCH values: IRWrite=1, NextPC=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10; all others 0.

Verification
REQ-022 ADD R1,R2,R3 (Op=00, Funct=001000, Rd=0001) -> FETCH, DECODE, EXECR, ALUWB, FETCH; ALUControl=00 and FlagW=00 in EXECR; RegW=1, PCS=0 in ALUWB.
REQ-023 LDR (Op=01, Funct=011001) -> MEMADR, MEMRD (AdrSrc=1), MEMWB (RegW=1, ResultSrc=01); STR (Funct=011000) -> MEMWR with MemW=1, RegW=0.
REQ-024 B (Op=10) -> BRANCH with PCS=1, ALUSrcB=01, ResultSrc=10; FETCH follows; 3 cycles total.
REQ-025 CMP immediate (Op=00, Funct=110101) -> EXECI with ALUControl=01, FlagW=11, NoWrite=1; ALUWB with RegW=1, NoWrite=1.
REQ-026 SUBS PC (Op=00, Funct=100101, Rd=1111) -> ALUWB with PCS=1. Assert RESET while in MEMWR -> MemW=0 in the same cycle, state FETCH; Op=11 -> DECODE then FETCH.
